// File: rtl/viterbi_decoder.sv
// viterbi_decoder
//   Hard-decision Viterbi decoder for the rate 1/2, K=3 convolutional code
//   G0=111, G1=101. Register-exchange survivors (16 bits per state) give a
//   fixed decision depth of 15 symbols.
//
//   Trellis state is {s1,s2}; input u moves {s1,s2} -> {u,s1}. The two
//   predecessors of state j are {j[0],0} and {j[0],1}; the branch input is j[1].
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (priority over enable)
//   enable     d_in carries a valid code symbol this cycle
//   d_in[1:0]  received symbol, [1] = G0 bit, [0] = G1 bit
//   d_out      decoded bit, registered
//   valid_o    d_out updated this cycle, registered
//   err_cnt_o  (only with VITERBI_ERR_CNT_EN) saturating running sum of the
//              minimum per-symbol metric increment, i.e. estimated bit errors
//
// Build option
//   VITERBI_ERR_CNT_EN  adds err_cnt_o and its accumulator.

module viterbi_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] d_in,
  output logic       d_out,
`ifdef VITERBI_ERR_CNT_EN
  output logic       valid_o,
  output logic [15:0] err_cnt_o
`else
  output logic       valid_o
`endif
);

  localparam logic [4:0] CNT_FULL = 5'd16;

  logic [3:0]  pm_q     [4];
  logic [15:0] surv_q   [4];
  logic [4:0]  cnt_q;

  logic [4:0]  cand     [4];
  logic [15:0] surv_new [4];
  logic [3:0]  pm_new   [4];
  logic [4:0]  min_c;
  logic [1:0]  best;

  // Encoder output for a branch leaving state p={s1,s2} with input u.
  function automatic logic [1:0] exp_sym(input logic [1:0] p, input logic u);
    return {u ^ p[1] ^ p[0], u ^ p[0]};
  endfunction

  function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

  for (genvar j = 0; j < 4; j++) begin : g_acs
    localparam logic [1:0] P0 = 2'((j % 2) * 2);
    localparam logic [1:0] P1 = 2'((j % 2) * 2 + 1);
    localparam logic       U  = 1'(j / 2);

    logic [4:0]  cand0, cand1;
    logic        sel;
    logic [15:0] surv_sel;

    assign cand0    = {1'b0, pm_q[P0]} + {3'b000, hamming(d_in, exp_sym(P0, U))};
    assign cand1    = {1'b0, pm_q[P1]} + {3'b000, hamming(d_in, exp_sym(P1, U))};
    // Strict compare: on a tie the lower-index predecessor P0 survives.
    assign sel      = (cand1 < cand0);
    assign cand[j]  = sel ? cand1 : cand0;
    assign surv_sel = sel ? surv_q[P1] : surv_q[P0];
    assign surv_new[j] = {surv_sel[14:0], U};
  end

  // Minimum metric and best state; strict compare keeps the lowest index.
  always_comb begin
    min_c = cand[0];
    best  = 2'd0;
    for (int i = 1; i < 4; i++) begin
      if (cand[i] < min_c) begin
        min_c = cand[i];
        best  = 2'(i);
      end
    end
  end

  // Renormalised metrics: the spread of a K=3 hard-decision trellis stays
  // well below 16, so the difference always fits in 4 bits.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pm_new[i] = 4'(cand[i] - min_c);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        pm_q[i]   <= (i == 0) ? 4'd0 : 4'd4;
        surv_q[i] <= 16'd0;
      end
      cnt_q   <= 5'd0;
      d_out   <= 1'b0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (enable) begin
        for (int i = 0; i < 4; i++) begin
          pm_q[i]   <= pm_new[i];
          surv_q[i] <= surv_new[i];
        end
        if (cnt_q != CNT_FULL) cnt_q <= cnt_q + 5'd1;
        // This symbol is number cnt_q+1; output starts at the 16th.
        valid_o <= (cnt_q >= 5'd15);
        d_out   <= surv_new[best][15];
      end
    end
  end

`ifdef VITERBI_ERR_CNT_EN
  // Metrics were renormalised to a minimum of 0 last cycle (and reset to a
  // minimum of 0), so the smallest new candidate is the minimum increment.
  logic [16:0] err_sum;
  assign err_sum = {1'b0, err_cnt_o} + {12'd0, min_c};

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_o <= 16'd0;
    end else if (enable) begin
      err_cnt_o <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// Testbench for viterbi_decoder: directed streams with hand-computed
// symbols/bits, enable gaps, mid-stream reset, a channel with isolated
// double-bit errors, and an all-zero tie-break stream.

module tb_viterbi_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [1:0] d_in;
  logic       d_out;
  logic       valid_o;
`ifdef VITERBI_ERR_CNT_EN
  logic [15:0] err_cnt_o;
`endif

  viterbi_decoder dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .d_in      (d_in),
    .d_out     (d_out),
`ifdef VITERBI_ERR_CNT_EN
    .valid_o   (valid_o),
    .err_cnt_o (err_cnt_o)
`else
    .valid_o   (valid_o)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] q_sym[$];
  logic       q_bit[$];
  logic       s1, s2;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    enable = 1'b0;
    @(posedge clk); #1;
    rst    = 1'b0;
  endtask

  task automatic send(input logic [1:0] sym);
    enable = 1'b1;
    d_in   = sym;
    @(posedge clk); #1;
    enable = 1'b0;
  endtask

  // Hand-computed: bits 1,0,1,1,0,0 -> 11,10,00,01,01,11, then 00 symbols.
  task automatic load_clean(input int n);
    logic [1:0] syms[6];
    logic       bits[6];
    syms = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    q_sym.delete();
    q_bit.delete();
    for (int i = 0; i < n; i++) begin
      q_sym.push_back(i < 6 ? syms[i] : 2'b00);
      q_bit.push_back(i < 6 ? bits[i] : 1'b0);
    end
  endtask

  task automatic push_encoded(input logic b, input logic flip);
    logic [1:0] sym;
    sym = {b ^ s1 ^ s2, b ^ s2};
    s2  = s1;
    s1  = b;
    q_sym.push_back(flip ? ~sym : sym);
    q_bit.push_back(b);
  endtask

  task automatic run_stream(input string tag, input bit gaps);
    logic held;
    for (int k = 1; k <= q_sym.size(); k++) begin
      if (gaps) begin
        held = d_out;
        for (int g = 0; g < (k * 7) % 4; g++) begin
          @(posedge clk); #1;
          check({tag, "_gap_valid"}, 32'(valid_o), 32'd0);
          check({tag, "_gap_dout"}, 32'(d_out), 32'(held));
        end
      end
      send(q_sym[k-1]);
      check({tag, "_valid"}, 32'(valid_o), 32'(k >= 16));
      if (k >= 16) check({tag, "_dout"}, 32'(d_out), 32'(q_bit[k-16]));
    end
  endtask

  initial begin
    int last_err;
    logic b, flip;

    rst    = 1'b0;
    enable = 1'b0;
    d_in   = 2'b00;

    // Reset state
    do_reset();
    check("rst_dout", 32'(d_out), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
`ifdef VITERBI_ERR_CNT_EN
    check("rst_errcnt", 32'(err_cnt_o), 32'd0);
`endif

    // Clean stream
    load_clean(21);
    run_stream("clean", 1'b0);
`ifdef VITERBI_ERR_CNT_EN
    check("clean_errcnt", 32'(err_cnt_o), 32'd0);
`endif
    // Idle cycle after a valid output: valid drops, d_out holds
    @(posedge clk); #1;
    check("idle_valid", 32'(valid_o), 32'd0);
    check("idle_dout", 32'(d_out), 32'(q_bit[5]));

    // Double error in symbol 3 (00 received as 11)
    do_reset();
    load_clean(21);
    q_sym[2] = 2'b11;
    run_stream("dbl", 1'b0);
`ifdef VITERBI_ERR_CNT_EN
    check("dbl_errcnt", 32'(err_cnt_o), 32'd2);
`endif

    // Enable gaps
    do_reset();
    load_clean(21);
    run_stream("gap", 1'b1);

    // Mid-stream reset after 20 symbols; reset wins over enable
    do_reset();
    load_clean(20);
    run_stream("pre_rst", 1'b0);
    rst    = 1'b1;
    enable = 1'b1;
    d_in   = 2'b11;
    @(posedge clk); #1;
    rst    = 1'b0;
    enable = 1'b0;
    check("midrst_valid", 32'(valid_o), 32'd0);
    check("midrst_dout", 32'(d_out), 32'd0);
`ifdef VITERBI_ERR_CNT_EN
    check("midrst_errcnt", 32'(err_cnt_o), 32'd0);
`endif
    q_sym.delete();
    q_bit.delete();
    s1 = 1'b0;
    s2 = 1'b0;
    foreach (q_bit[i]) ;
    for (int i = 0; i < 26; i++) begin
      b = (i < 10) ? 1'(((10'b0111010011) >> i) & 10'd1) : 1'b0;
      push_encoded(b, 1'b0);
    end
    run_stream("post_rst", 1'b0);

    // Random channel, isolated double-bit errors at least 16 clean symbols apart
    do_reset();
    q_sym.delete();
    q_bit.delete();
    s1 = 1'b0;
    s2 = 1'b0;
    last_err = -100;
    for (int i = 0; i < 271; i++) begin
      b    = (i < 256) ? 1'($urandom_range(1)) : 1'b0;
      flip = 1'b0;
      if ((i - last_err) > 16 && $urandom_range(15) == 0) begin
        flip     = 1'b1;
        last_err = i;
      end
      push_encoded(b, flip);
    end
    run_stream("rand", 1'b0);

    // All-zero stream: tie-break keeps state 0, output stays 0
    do_reset();
    q_sym.delete();
    q_bit.delete();
    for (int i = 0; i < 40; i++) begin
      q_sym.push_back(2'b00);
      q_bit.push_back(1'b0);
    end
    run_stream("zero", 1'b0);
`ifdef VITERBI_ERR_CNT_EN
    check("zero_errcnt", 32'(err_cnt_o), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
